// File: rtl/updown_count_monitor_if.sv
// Bus between the up/down counter side and its monitor: the sampled count
// plus every status output the monitor reports back.
interface updown_count_monitor_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ERR_W = 8
);
    logic             count_valid;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] last_count;
    logic             dir_up;
    logic             dir_down;
    logic             holding;
    logic             step_error;
    logic             wrap_up;
    logic             wrap_down;
    logic             dir_change;
    logic [ERR_W-1:0] err_count;
    logic             synced;

    modport master (
        output count_valid, count,
        input  last_count, dir_up, dir_down, holding, step_error,
               wrap_up, wrap_down, dir_change, err_count, synced
    );

    modport slave (
        input  count_valid, count,
        output last_count, dir_up, dir_down, holding, step_error,
               wrap_up, wrap_down, dir_change, err_count, synced
    );
endinterface

// File: rtl/updown_count_monitor.sv
// Observer for an up/down counter bus: classifies each accepted step as
// hold/up/down/illegal, flags wraps and reversals, and tallies errors.
module updown_count_monitor #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ERR_W = 8
) (
    input  logic                  clock,
    input  logic                  clear,
    updown_count_monitor_if.slave bus
);
    typedef enum logic [2:0] {S_INIT, S_HOLD, S_UP, S_DOWN, S_ERR} state_t;
    typedef enum logic [1:0] {D_NONE, D_UP, D_DOWN} dir_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    dir_t             last_dir_q, last_dir_d;
    logic [WIDTH-1:0] last_count_q, last_count_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             synced_q, synced_d;
    logic             step_error_q, step_error_d;
    logic             wrap_up_q, wrap_up_d;
    logic             wrap_down_q, wrap_down_d;
    logic             dir_change_q, dir_change_d;
    logic [WIDTH-1:0] delta;

    always_comb begin
        state_d      = state_q;
        last_dir_d   = last_dir_q;
        last_count_d = last_count_q;
        err_d        = err_q;
        synced_d     = synced_q;
        step_error_d = 1'b0;
        wrap_up_d    = 1'b0;
        wrap_down_d  = 1'b0;
        dir_change_d = 1'b0;
        delta        = bus.count - last_count_q;

        if (bus.count_valid) begin
            last_count_d = bus.count;
            if (state_q == S_INIT) begin
                // First sample after reset only establishes the reference.
                state_d  = S_HOLD;
                synced_d = 1'b1;
            end else if (delta == '0) begin
                state_d = S_HOLD;
            end else if (delta == ONE) begin
                state_d      = S_UP;
                last_dir_d   = D_UP;
                wrap_up_d    = (last_count_q == '1) && (bus.count == '0);
                dir_change_d = (last_dir_q == D_DOWN);
            end else if (delta == '1) begin
                state_d      = S_DOWN;
                last_dir_d   = D_DOWN;
                wrap_down_d  = (last_count_q == '0) && (bus.count == '1);
                dir_change_d = (last_dir_q == D_UP);
            end else begin
                state_d      = S_ERR;
                step_error_d = 1'b1;
                if (err_q != '1) begin
                    err_d = err_q + ERR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q      <= S_INIT;
            last_dir_q   <= D_NONE;
            last_count_q <= '0;
            err_q        <= '0;
            synced_q     <= 1'b0;
            step_error_q <= 1'b0;
            wrap_up_q    <= 1'b0;
            wrap_down_q  <= 1'b0;
            dir_change_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_dir_q   <= last_dir_d;
            last_count_q <= last_count_d;
            err_q        <= err_d;
            synced_q     <= synced_d;
            step_error_q <= step_error_d;
            wrap_up_q    <= wrap_up_d;
            wrap_down_q  <= wrap_down_d;
            dir_change_q <= dir_change_d;
        end
    end

    assign bus.last_count = last_count_q;
    assign bus.dir_up     = (state_q == S_UP);
    assign bus.dir_down   = (state_q == S_DOWN);
    assign bus.holding    = (state_q == S_HOLD);
    assign bus.step_error = step_error_q;
    assign bus.wrap_up    = wrap_up_q;
    assign bus.wrap_down  = wrap_down_q;
    assign bus.dir_change = dir_change_q;
    assign bus.err_count  = err_q;
    assign bus.synced     = synced_q;
endmodule

// File: tb/tb_updown_count_monitor.sv
// Directed bench for updown_count_monitor; flags are checked as the packed
// vector {synced, dir_up, dir_down, holding, step_error, wrap_up, wrap_down, dir_change}.
module tb_updown_count_monitor;
    logic clock = 1'b0;
    logic clear = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    updown_count_monitor_if #(.WIDTH(16), .ERR_W(8)) bus ();

    updown_count_monitor #(.WIDTH(16), .ERR_W(8)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] flags();
        return {bus.synced, bus.dir_up, bus.dir_down, bus.holding,
                bus.step_error, bus.wrap_up, bus.wrap_down, bus.dir_change};
    endfunction

    task automatic do_reset();
        @(negedge clock);
        bus.count_valid = 1'b0;
        bus.count       = '0;
        clear           = 1'b0;
        #2;
        clear = 1'b1;
    endtask

    task automatic sample(input logic [15:0] v);
        @(negedge clock);
        bus.count_valid = 1'b1;
        bus.count       = v;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        @(negedge clock);
        bus.count_valid = 1'b0;
        bus.count       = 16'hDEAD;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        bus.count_valid = 1'b0;
        bus.count       = '0;
        clear = 1'b0;
        #3;
        compared++; if (flags() !== 8'b0000_0000) begin mismatched++; $display("FAIL reset_flags got %b want %b", flags(), 8'b0); end
        compared++; if (bus.err_count !== 8'd0 || bus.last_count !== 16'd0) begin mismatched++; $display("FAIL reset_regs err=%0d last=%h want 0/0", bus.err_count, bus.last_count); end
        clear = 1'b1;
    endtask

    task automatic test_count_up();
        do_reset();
        sample(16'd5);
        compared++; if (flags() !== 8'b1001_0000) begin mismatched++; $display("FAIL up_first got %b want %b", flags(), 8'b1001_0000); end
        sample(16'd6);
        compared++; if (flags() !== 8'b1100_0000) begin mismatched++; $display("FAIL up_second got %b want %b", flags(), 8'b1100_0000); end
        sample(16'd7);
        compared++; if (flags() !== 8'b1100_0000) begin mismatched++; $display("FAIL up_third got %b want %b", flags(), 8'b1100_0000); end
        compared++; if (bus.err_count !== 8'd0 || bus.last_count !== 16'd7) begin mismatched++; $display("FAIL up_regs err=%0d last=%0d want 0/7", bus.err_count, bus.last_count); end
    endtask

    task automatic test_wrap_up();
        do_reset();
        sample(16'hFFFE);
        sample(16'hFFFF);
        compared++; if (flags() !== 8'b1100_0000) begin mismatched++; $display("FAIL wrapup_pre got %b want %b", flags(), 8'b1100_0000); end
        sample(16'h0000);
        compared++; if (flags() !== 8'b1100_0100) begin mismatched++; $display("FAIL wrapup_pulse got %b want %b", flags(), 8'b1100_0100); end
        idle(1);
        compared++; if (flags() !== 8'b1100_0000) begin mismatched++; $display("FAIL wrapup_clear got %b want %b", flags(), 8'b1100_0000); end
    endtask

    task automatic test_hold_reverse();
        do_reset();
        sample(16'd10);
        sample(16'd11);
        compared++; if (flags() !== 8'b1100_0000) begin mismatched++; $display("FAIL hold_up got %b want %b", flags(), 8'b1100_0000); end
        sample(16'd11);
        compared++; if (flags() !== 8'b1001_0000) begin mismatched++; $display("FAIL hold_1 got %b want %b", flags(), 8'b1001_0000); end
        sample(16'd11);
        compared++; if (flags() !== 8'b1001_0000) begin mismatched++; $display("FAIL hold_2 got %b want %b", flags(), 8'b1001_0000); end
        sample(16'd10);
        compared++; if (flags() !== 8'b1010_0001) begin mismatched++; $display("FAIL reverse got %b want %b", flags(), 8'b1010_0001); end
        sample(16'd9);
        compared++; if (flags() !== 8'b1010_0000) begin mismatched++; $display("FAIL down_cont got %b want %b", flags(), 8'b1010_0000); end
    endtask

    task automatic test_error_resync();
        do_reset();
        sample(16'd100);
        sample(16'd101);
        sample(16'd200);
        compared++; if (flags() !== 8'b1000_1000) begin mismatched++; $display("FAIL err_pulse got %b want %b", flags(), 8'b1000_1000); end
        compared++; if (bus.err_count !== 8'd1) begin mismatched++; $display("FAIL err_count1 got %0d want 1", bus.err_count); end
        sample(16'd201);
        compared++; if (flags() !== 8'b1100_0000) begin mismatched++; $display("FAIL err_resync got %b want %b", flags(), 8'b1100_0000); end
        compared++; if (bus.err_count !== 8'd1 || bus.last_count !== 16'd201) begin mismatched++; $display("FAIL err_hold err=%0d last=%0d want 1/201", bus.err_count, bus.last_count); end
    endtask

    task automatic test_saturation();
        do_reset();
        sample(16'd0);
        for (int i = 1; i <= 300; i++) begin
            sample(16'(2 * i));
            compared++; if (flags() !== 8'b1000_1000) begin mismatched++; $display("FAIL sat_flags[%0d] got %b want %b", i, flags(), 8'b1000_1000); end
            compared++; if (bus.err_count !== 8'((i < 255) ? i : 255)) begin mismatched++; $display("FAIL sat_count[%0d] got %0d want %0d", i, bus.err_count, (i < 255) ? i : 255); end
        end
    endtask

    task automatic test_wrap_down_reversal();
        do_reset();
        sample(16'hFFFF);
        sample(16'h0000);
        compared++; if (flags() !== 8'b1100_0100) begin mismatched++; $display("FAIL wd_pre got %b want %b", flags(), 8'b1100_0100); end
        sample(16'hFFFF);
        compared++; if (flags() !== 8'b1010_0011) begin mismatched++; $display("FAIL wd_rev got %b want %b", flags(), 8'b1010_0011); end
        compared++; if (bus.err_count !== 8'd0) begin mismatched++; $display("FAIL wd_err got %0d want 0", bus.err_count); end
    endtask

    task automatic test_gap();
        do_reset();
        sample(16'd20);
        idle(3);
        compared++; if (flags() !== 8'b1001_0000 || bus.last_count !== 16'd20) begin mismatched++; $display("FAIL gap_hold got %b/%0d want %b/20", flags(), bus.last_count, 8'b1001_0000); end
        sample(16'd21);
        compared++; if (flags() !== 8'b1100_0000) begin mismatched++; $display("FAIL gap_up got %b want %b", flags(), 8'b1100_0000); end
        idle(2);
        compared++; if (flags() !== 8'b1100_0000) begin mismatched++; $display("FAIL gap_idle got %b want %b", flags(), 8'b1100_0000); end
    endtask

    task automatic test_async_reset();
        do_reset();
        sample(16'd50);
        sample(16'd60);
        sample(16'd70);
        sample(16'd80);
        sample(16'd79);
        compared++; if (flags() !== 8'b1010_0000 || bus.err_count !== 8'd3) begin mismatched++; $display("FAIL ar_pre got %b/%0d want %b/3", flags(), bus.err_count, 8'b1010_0000); end
        #1;
        clear = 1'b0;
        #1;
        compared++; if (flags() !== 8'b0000_0000) begin mismatched++; $display("FAIL ar_flags got %b want %b", flags(), 8'b0); end
        compared++; if (bus.err_count !== 8'd0 || bus.last_count !== 16'd0) begin mismatched++; $display("FAIL ar_regs err=%0d last=%h want 0/0", bus.err_count, bus.last_count); end
        @(negedge clock);
        bus.count_valid = 1'b0;
        clear = 1'b1;
        sample(16'h1234);
        compared++; if (flags() !== 8'b1001_0000) begin mismatched++; $display("FAIL ar_resync got %b want %b", flags(), 8'b1001_0000); end
        compared++; if (bus.err_count !== 8'd0 || bus.last_count !== 16'h1234) begin mismatched++; $display("FAIL ar_regs2 err=%0d last=%h want 0/1234", bus.err_count, bus.last_count); end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_hold_reverse();
        test_error_resync();
        test_saturation();
        test_wrap_down_reversal();
        test_gap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/updown_count_monitor.md
# updown_count_monitor

Receiving-end checker for the 16-bit up/down counter's `count` bus. It samples the bus on qualified cycles and classifies each step as hold, up-by-one, down-by-one or illegal. It also tracks direction, flags wrap-around and direction reversals, and keeps a saturating error tally. It sits beside the counter in the datapath and in benches as a self-checking observer. It never drives the counter.

## Interface
- `WIDTH`, 16, width of the observed count bus
- `ERR_W`, 8, width of the saturating error counter
- `clock`  in  1  rising-edge clock, shared with the counter
- `clear`  in  1  asynchronous, active-low reset
- `count_valid`  in  1  qualifies `count` on this edge
- `count`  in  WIDTH  observed counter value
- `last_count`  out  WIDTH  most recently accepted sample
- `dir_up`  out  1  level: current state is UP
- `dir_down`  out  1  level: current state is DOWN
- `holding`  out  1  level: current state is HOLD
- `step_error`  out  1  one-cycle pulse: illegal step seen
- `wrap_up`  out  1  one-cycle pulse: step from all-ones to 0
- `wrap_down`  out  1  one-cycle pulse: step from 0 to all-ones
- `dir_change`  out  1  one-cycle pulse: direction reversed
- `err_count`  out  ERR_W  saturating count of illegal steps
- `synced`  out  1  level: at least one sample accepted since reset

## Operation
- States: INIT, HOLD, UP, DOWN, ERR.
- `clear` low puts the block in INIT. The state is held while `count_valid` is 0.
- Accepted sample: `count_valid` is 1 at a rising edge. Every accepted sample loads `last_count`. On the accepted cycle `prev` is the old `last_count`, and `delta = (count - prev)` mod 2^WIDTH.
- In INIT, the first accepted sample only captures `last_count`:
  - state goes to HOLD and `synced` goes to 1
  - no pulses are raised and `last_dir` is not updated
- From any of HOLD, UP, DOWN or ERR, the next state depends on `delta`:
  - `delta` = 0 goes to HOLD
  - `delta` = 1 goes to UP
  - `delta` = 2^WIDTH-1 goes to DOWN
  - any other value goes to ERR
- ERR lasts for one accepted sample. The next accepted sample is classified normally against the new `last_count`, so the monitor resyncs without a reset.
- `step_error` pulses on every transition into ERR, including ERR to ERR. `err_count` increments on the same edge, saturating at 2^ERR_W-1.
- `wrap_up` pulses when `prev` = 2^WIDTH-1 and `count` = 0. `wrap_down` pulses when `prev` = 0 and `count` = 2^WIDTH-1. Wraps are legal steps and do not count as errors.
- `last_dir` is an internal register holding none, up or down. Only UP or DOWN steps update it. HOLD and ERR leave it unchanged.
- `dir_change` pulses when an UP step arrives with `last_dir` = down, or a DOWN step arrives with `last_dir` = up. HOLD samples in between do not mask a reversal.
- Decoding of `dir_up`, `dir_down` and `holding`:
  - each is one-hot to its own state
  - all three are 0 in INIT and ERR
- The subtraction is WIDTH-bit modular. No wider intermediate result is used.

## Timing
- All outputs are registered. Effects of the sample taken at edge N are visible after edge N.
- Pulse outputs are high for exactly one clock and are 0 on any cycle with no accepted sample.
- Reset values: `last_count` = 0, `err_count` = 0, all flags and pulses 0, state INIT, `last_dir` = none.
- Reset is asynchronous on assertion and takes effect mid-operation without waiting for a clock edge.
- After release, the first accepted sample is taken from INIT. It is never checked against the pre-reset value.
- Gaps in `count_valid` are transparent. Samples are compared only with the previous accepted sample.
- When a step is both a wrap and a reversal (for example UP steps, then 0 to all-ones), `wrap_down` and `dir_change` pulse on the same cycle.

## Test plan
- Reset, then `count_valid`=1 with `count` = 5, 6, 7 -> `synced`=1 after the first edge. `dir_up`=1 from the second sample. No pulses. `err_count`=0.
- Count 0xFFFE, 0xFFFF, 0x0000 -> `wrap_up` for one cycle on the third sample. `dir_up` stays 1. `step_error`=0.
- Count 10, 11, 11, 11, 10 -> HOLD (`holding`=1) on the repeated values. `dir_change` pulses on the sample 10. `dir_down`=1 afterwards.
- Count 100, 101, 200, 201 -> `step_error` pulses on 200 and `err_count`=1. `dir_up`=1 again on 201, with no further error.
- 300 non-unit steps in a row -> `err_count` saturates at 255 and `step_error` pulses on every sample.
- Pull `clear` low between clock edges while in DOWN with `err_count`=3 -> all outputs are 0 immediately. After release, the sample 0x1234 only resyncs: no error, no pulses.
